// File: rtl/control.sv
// Main RV32I decoder: instr -> datapath controls + 4-bit ALU op; sticky illegal-opcode flag.
// Latency: decode is combinational (same cycle); illegal_seen updates on the next clk edge.
// Backpressure: none; optional OP-IMM decode enabled by CONTROL_ITYPE_ALU_EN.
module control (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic        branch,
    output logic        memread,
    output logic        memtoreg,
    output logic [3:0]  aluctrl,
    output logic        alusrc,
    output logic        memwrite,
    output logic        regwrite,
    output logic        illegal,
    output logic        illegal_seen
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
`ifdef CONTROL_ITYPE_ALU_EN
    localparam logic [6:0] OP_IMM    = 7'b0010011;
`endif

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef struct packed {
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [3:0] aluctrl;
    } ctrl_t;

    ctrl_t       ctrl;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        unused_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    // Register indices and immediates are consumed by the datapath, not the decoder.
    assign unused_bits = &{instr[31], instr[29:15], instr[11:7], 1'b0};

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (opcode)
            OP_LOAD:   ctrl = '{alusrc: 1'b1, memtoreg: 1'b1, regwrite: 1'b1, memread: 1'b1,
                                memwrite: 1'b0, branch: 1'b0, aluctrl: ALU_ADD};
            OP_STORE:  ctrl = '{alusrc: 1'b1, memtoreg: 1'b0, regwrite: 1'b0, memread: 1'b0,
                                memwrite: 1'b1, branch: 1'b0, aluctrl: ALU_ADD};
            OP_BRANCH: ctrl = '{alusrc: 1'b0, memtoreg: 1'b0, regwrite: 1'b0, memread: 1'b0,
                                memwrite: 1'b0, branch: 1'b1, aluctrl: ALU_SUB};
            OP_REG: begin
                ctrl.regwrite = 1'b1;
                case ({instr[30], funct3})
                    4'b1000: ctrl.aluctrl = ALU_SUB;
                    4'b0111: ctrl.aluctrl = ALU_AND;
                    4'b0110: ctrl.aluctrl = ALU_OR;
                    default: ctrl.aluctrl = ALU_ADD;
                endcase
            end
`ifdef CONTROL_ITYPE_ALU_EN
            OP_IMM: begin
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
                case (funct3)
                    3'b111:  ctrl.aluctrl = ALU_AND;
                    3'b110:  ctrl.aluctrl = ALU_OR;
                    default: ctrl.aluctrl = ALU_ADD;
                endcase
            end
`endif
            default: illegal = 1'b1;
        endcase
    end

    assign alusrc   = ctrl.alusrc;
    assign memtoreg = ctrl.memtoreg;
    assign regwrite = ctrl.regwrite;
    assign memread  = ctrl.memread;
    assign memwrite = ctrl.memwrite;
    assign branch   = ctrl.branch;
    assign aluctrl  = ctrl.aluctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_seen <= 1'b0;
        end else begin
            illegal_seen <= illegal_seen | illegal;
        end
    end

endmodule

// File: tb/tb_control.sv
// Directed table of decode vectors plus hand-written sequences for the sticky illegal flag.
module tb_control;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        branch, memread, memtoreg, alusrc, memwrite, regwrite;
    logic        illegal, illegal_seen;
    logic [3:0]  aluctrl;

    int checks = 0;
    int errors = 0;

    control dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .branch       (branch),
        .memread      (memread),
        .memtoreg     (memtoreg),
        .aluctrl      (aluctrl),
        .alusrc       (alusrc),
        .memwrite     (memwrite),
        .regwrite     (regwrite),
        .illegal      (illegal),
        .illegal_seen (illegal_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  ctrl;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [9:0] ctrl_bus();
        return {alusrc, memtoreg, regwrite, memread, memwrite, branch, aluctrl};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] w);
        @(negedge clk);
        instr = w;
        #1;
    endtask

    initial begin
        // lw
        vecs.push_back('{32'h0080af03, 10'b1111000010, 1'b0});
        vecs.push_back('{32'hff80af03, 10'b1111000010, 1'b0});
        vecs.push_back('{32'h0200a283, 10'b1111000010, 1'b0});
        // sw
        vecs.push_back('{32'h0020a223, 10'b1000100010, 1'b0});
        vecs.push_back('{32'hfe20aa23, 10'b1000100010, 1'b0});
        vecs.push_back('{32'h0020a023, 10'b1000100010, 1'b0});
        // beq
        vecs.push_back('{32'h00208463, 10'b0000010110, 1'b0});
        vecs.push_back('{32'h00208663, 10'b0000010110, 1'b0});
        vecs.push_back('{32'hfeb289e3, 10'b0000010110, 1'b0});
        // R-type: sub, or, add, and, xor falls back to add
        vecs.push_back('{32'h40208f33, 10'b0010000110, 1'b0});
        vecs.push_back('{32'h0020ef33, 10'b0010000001, 1'b0});
        vecs.push_back('{32'h00208f33, 10'b0010000010, 1'b0});
        vecs.push_back('{32'h0020ff33, 10'b0010000000, 1'b0});
        vecs.push_back('{32'h0020cf33, 10'b0010000010, 1'b0});
        // unsupported opcodes: custom, lui, jal
        vecs.push_back('{32'h0000007f, 10'b0000000000, 1'b1});
        vecs.push_back('{32'h123450b7, 10'b0000000000, 1'b1});
        vecs.push_back('{32'h0080006f, 10'b0000000000, 1'b1});
`ifdef CONTROL_ITYPE_ALU_EN
        vecs.push_back('{32'h00108093, 10'b1010000010, 1'b0});  // addi
        vecs.push_back('{32'h0ff0f093, 10'b1010000000, 1'b0});  // andi
        vecs.push_back('{32'h0010e093, 10'b1010000001, 1'b0});  // ori
        vecs.push_back('{32'h0010c093, 10'b1010000010, 1'b0});  // xori -> add
`else
        vecs.push_back('{32'h00108093, 10'b0000000000, 1'b1});
`endif

        rst   = 1'b1;
        instr = 32'h00208f33;
        #2;
        check("reset illegal_seen", {31'b0, illegal_seen}, 32'd0);

        // Decode runs while rst is held, so illegal vectors must not set the flag.
        foreach (vecs[i]) begin
            drive(vecs[i].instr);
            check($sformatf("ctrl[%0d] %h", i, vecs[i].instr), {22'b0, ctrl_bus()}, {22'b0, vecs[i].ctrl});
            check($sformatf("illegal[%0d] %h", i, vecs[i].instr), {31'b0, illegal}, {31'b0, vecs[i].ill});
        end
        @(posedge clk);
        #1;
        check("illegal_seen held in reset", {31'b0, illegal_seen}, 32'd0);

        // Legal traffic after reset leaves the flag clear.
        drive(32'h0080af03);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("illegal_seen after legal", {31'b0, illegal_seen}, 32'd0);

        // Illegal opcode: visible combinationally now, latched at the next edge.
        drive(32'h0000007f);
        check("illegal comb", {31'b0, illegal}, 32'd1);
        check("illegal ctrl zero", {22'b0, ctrl_bus()}, 32'd0);
        check("illegal_seen before edge", {31'b0, illegal_seen}, 32'd0);
        @(posedge clk);
        #1;
        check("illegal_seen set", {31'b0, illegal_seen}, 32'd1);

        drive(32'h0080af03);
        check("lw after illegal", {22'b0, ctrl_bus()}, {22'b0, 10'b1111000010});
        repeat (3) @(posedge clk);
        #1;
        check("illegal_seen sticky", {31'b0, illegal_seen}, 32'd1);

        // Asynchronous clear between edges.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async clear", {31'b0, illegal_seen}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("clear holds", {31'b0, illegal_seen}, 32'd0);

        // OP-IMM sets the flag only when the feature is off.
        drive(32'h00108093);
        @(posedge clk);
        #1;
`ifdef CONTROL_ITYPE_ALU_EN
        check("addi no sticky", {31'b0, illegal_seen}, 32'd0);
`else
        check("addi sticky", {31'b0, illegal_seen}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "timeout");
    end

endmodule
